// File: rtl/ctrl_sequencer_pkg.sv
// Shared types and default parameters for the control sequencer.
package ctrl_sequencer_pkg;

    localparam int unsigned DefOpcW  = 3;
    localparam int unsigned DefSteps = 5;
    localparam logic [(2**DefOpcW)-1:0] DefCondMask = 8'b0100_0000;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StIncr,
        StExec,
        StPause
    } state_e;

endpackage

// File: rtl/onehot_dec.sv
// Binary to one-hot decoder with an enable; all outputs low when disabled.
module onehot_dec #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SEL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             en_i,
    input  logic [SEL_W-1:0] sel_i,
    output logic [WIDTH-1:0] oh_o
);

    always_comb begin
        oh_o = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            oh_o[i] = en_i && (sel_i == SEL_W'(i));
        end
    end

endmodule

// File: rtl/ctrl_sequencer.sv
// Instruction sequencer: FETCH/INCR/EXEC phases of STEPS cycles each, with
// conditional EXEC bypass, single-step pause and a completed-instruction counter.
module ctrl_sequencer
    import ctrl_sequencer_pkg::*;
#(
    parameter int unsigned         OPC_W     = DefOpcW,
    parameter int unsigned         STEPS     = DefSteps,
    parameter logic [2**OPC_W-1:0] COND_MASK = DefCondMask,
    parameter int unsigned         CNT_W     = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                run,
    input  logic                single_step,
    input  logic                step_req,
    input  logic [OPC_W-1:0]    opcode,
    input  logic                cond,
    output logic                fetch_act,
    output logic                incr_act,
    output logic                exec_act,
    output logic [STEPS-1:0]    step_oh,
    output logic [2**OPC_W-1:0] op_oh,
    output logic                busy,
    output logic                done,
    output logic                skipped,
    output logic [CNT_W-1:0]    instr_cnt
);

    localparam int unsigned StepW  = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int unsigned NumOps = 2**OPC_W;

    state_e             state_q, state_d;
    logic [StepW-1:0]   step_q, step_d;
    logic [OPC_W-1:0]   op_q, op_d;
    logic               done_q, done_d;
    logic               skipped_q, skipped_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               step_last, complete, bypass;

    assign step_last = (step_q == StepW'(STEPS - 1));

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        op_d      = op_q;
        done_d    = 1'b0;
        skipped_d = 1'b0;
        cnt_d     = cnt_q;
        complete  = 1'b0;
        bypass    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StFetch;
                    step_d  = '0;
                end
            end
            StFetch, StIncr, StExec: begin
                if (step_last) begin
                    step_d = '0;
                    if (state_q == StFetch) begin
                        state_d = StIncr;
                    end else if (state_q == StIncr) begin
                        // Opcode and cond are only looked at here; EXEC ignores them.
                        op_d = opcode;
                        if (COND_MASK[opcode] && !cond) begin
                            bypass   = 1'b1;
                            complete = 1'b1;
                        end else begin
                            state_d = StExec;
                        end
                    end else begin
                        complete = 1'b1;
                    end
                end else begin
                    step_d = step_q + StepW'(1);
                end
            end
            StPause: begin
                if (!run) begin
                    state_d = StIdle;
                end else if (step_req) begin
                    state_d = StFetch;
                    step_d  = '0;
                end
            end
            default: state_d = StIdle;
        endcase

        if (complete) begin
            done_d    = 1'b1;
            skipped_d = bypass;
            cnt_d     = cnt_q + CNT_W'(1);
            step_d    = '0;
            if (!run) begin
                state_d = StIdle;
            end else if (single_step) begin
                state_d = StPause;
            end else begin
                state_d = StFetch;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            step_q    <= '0;
            op_q      <= '0;
            done_q    <= 1'b0;
            skipped_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            op_q      <= op_d;
            done_q    <= done_d;
            skipped_q <= skipped_d;
            cnt_q     <= cnt_d;
        end
    end

    assign fetch_act = (state_q == StFetch);
    assign incr_act  = (state_q == StIncr);
    assign exec_act  = (state_q == StExec);
    assign busy      = (state_q != StIdle);
    assign done      = done_q;
    assign skipped   = skipped_q;
    assign instr_cnt = cnt_q;

    onehot_dec #(
        .WIDTH (STEPS),
        .SEL_W (StepW)
    ) u_step_dec (
        .en_i  (fetch_act | incr_act | exec_act),
        .sel_i (step_q),
        .oh_o  (step_oh)
    );

    onehot_dec #(
        .WIDTH (NumOps),
        .SEL_W (OPC_W)
    ) u_op_dec (
        .en_i  (exec_act),
        .sel_i (op_q),
        .oh_o  (op_oh)
    );

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Bench for ctrl_sequencer: directed vector table, corner-case sequences and
// randomized stimulus compared each cycle against an instruction-timeline model.
module tb_ctrl_sequencer;

    localparam int unsigned STEPS = 5;
    localparam logic [7:0]  MASK  = 8'b0100_0000;

    logic       clk = 1'b0;
    logic       reset, start, run, single_step, step_req, cond;
    logic [2:0] opcode;
    logic       fetch_act, incr_act, exec_act, busy, done, skipped;
    logic [4:0] step_oh;
    logic [7:0] op_oh;
    logic [3:0] instr_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference: mode 0 idle, 1 running an instruction, 2 paused.
    int m_mode, m_t, m_op, m_cnt;
    bit m_done, m_skip;

    always #5 clk = ~clk;

    ctrl_sequencer #(
        .OPC_W       (3),
        .STEPS       (STEPS),
        .COND_MASK   (MASK),
        .CNT_W       (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .run         (run),
        .single_step (single_step),
        .step_req    (step_req),
        .opcode      (opcode),
        .cond        (cond),
        .fetch_act   (fetch_act),
        .incr_act    (incr_act),
        .exec_act    (exec_act),
        .step_oh     (step_oh),
        .op_oh       (op_oh),
        .busy        (busy),
        .done        (done),
        .skipped     (skipped),
        .instr_cnt   (instr_cnt)
    );

    function automatic logic [22:0] dut_vec();
        return {fetch_act, incr_act, exec_act, busy, done, skipped, step_oh, op_oh, instr_cnt};
    endfunction

    function automatic logic [22:0] model_vec();
        logic [2:0] act = 3'b000;
        logic [4:0] so  = 5'b0;
        logic [7:0] oo  = 8'b0;
        int ph;
        if (m_mode == 1) begin
            ph  = m_t / STEPS;
            act = 3'b100 >> ph;
            so  = 5'(1) << (m_t % STEPS);
            if (ph == 2) oo = 8'(1) << m_op;
        end
        return {act, m_mode != 0, m_done, m_skip, so, oo, 4'(m_cnt)};
    endfunction

    // Advance the reference by one clock edge using the current inputs.
    task automatic model_step();
        bit fin, byp;
        if (reset) begin
            m_mode = 0; m_t = 0; m_op = 0; m_cnt = 0; m_done = 0; m_skip = 0;
            return;
        end
        m_done = 0;
        m_skip = 0;
        case (m_mode)
            0: if (start) begin m_mode = 1; m_t = 0; end
            2: begin
                if (!run) m_mode = 0;
                else if (step_req) begin m_mode = 1; m_t = 0; end
            end
            default: begin
                fin = 0;
                byp = 0;
                if (m_t == 2 * STEPS - 1) begin
                    m_op = int'(opcode);
                    byp  = MASK[m_op] && !cond;
                    fin  = byp;
                end
                if (m_t == 3 * STEPS - 1) fin = 1;
                if (fin) begin
                    m_done = 1;
                    m_skip = byp;
                    m_cnt  = (m_cnt + 1) % 16;
                    m_t    = 0;
                    m_mode = !run ? 0 : (single_step ? 2 : 1);
                end else begin
                    m_t++;
                end
            end
        endcase
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        check("model_cycle", 32'(dut_vec()), 32'(model_vec()));
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic r, input logic s, input logic rn, input logic ss,
                          input logic sr, input logic [2:0] op, input logic c);
        reset = r; start = s; run = rn; single_step = ss; step_req = sr; opcode = op; cond = c;
    endtask

    typedef struct {
        logic       rst, st, rn, ss, sr;
        logic [2:0] opc;
        logic       cnd;
        int         hold;
        logic [5:0] ctl;   // {fetch, incr, exec, busy, done, skipped}
        logic [4:0] so;
        logic [7:0] oo;
        logic [3:0] cnt;
    } vec_t;

    vec_t tbl[10];

    initial begin
        tbl[0] = '{1, 0, 0, 0, 0, 3'd0, 0, 1,  6'b000000, 5'b00000, 8'h00, 4'd0};
        tbl[1] = '{0, 1, 1, 0, 0, 3'd0, 0, 1,  6'b100100, 5'b00001, 8'h00, 4'd0};
        tbl[2] = '{0, 0, 1, 0, 0, 3'd0, 0, 4,  6'b100100, 5'b10000, 8'h00, 4'd0};
        tbl[3] = '{0, 0, 1, 0, 0, 3'd0, 0, 1,  6'b010100, 5'b00001, 8'h00, 4'd0};
        tbl[4] = '{0, 0, 1, 0, 0, 3'd0, 0, 5,  6'b001100, 5'b00001, 8'h01, 4'd0};
        tbl[5] = '{0, 0, 1, 0, 0, 3'd0, 0, 4,  6'b001100, 5'b10000, 8'h01, 4'd0};
        tbl[6] = '{0, 0, 1, 0, 0, 3'd0, 0, 1,  6'b100110, 5'b00001, 8'h00, 4'd1};
        tbl[7] = '{0, 0, 1, 0, 0, 3'd6, 0, 10, 6'b100111, 5'b00001, 8'h00, 4'd2};
        tbl[8] = '{0, 0, 1, 0, 0, 3'd6, 1, 10, 6'b001100, 5'b00001, 8'h40, 4'd2};
        tbl[9] = '{0, 0, 1, 0, 0, 3'd6, 1, 5,  6'b100110, 5'b00001, 8'h00, 4'd3};

        set_in(1, 0, 0, 0, 0, 3'd0, 0);
        model_step();
        @(posedge clk);
        #1;

        foreach (tbl[i]) begin
            set_in(tbl[i].rst, tbl[i].st, tbl[i].rn, tbl[i].ss, tbl[i].sr, tbl[i].opc, tbl[i].cnd);
            repeat (tbl[i].hold) tick();
            check($sformatf("vector%0d", i), 32'(dut_vec()),
                  32'({tbl[i].ctl, tbl[i].so, tbl[i].oo, tbl[i].cnt}));
        end

        // Single-step pause, release and exit to idle.
        set_in(1, 0, 0, 0, 0, 3'd0, 0); tick();
        set_in(0, 1, 1, 1, 0, 3'd0, 0); tick();
        start = 0;
        repeat (15) tick();
        check("pause_entry", 32'({busy, done, fetch_act, step_oh}), 32'({1'b1, 1'b1, 1'b0, 5'b0}));
        repeat (3) tick();
        check("pause_hold", 32'({busy, done, step_oh}), 32'({1'b1, 1'b0, 5'b0}));
        step_req = 1; tick(); step_req = 0;
        check("step_release", 32'({fetch_act, step_oh}), 32'({1'b1, 5'b00001}));
        repeat (15) tick();
        run = 0; tick();
        check("pause_to_idle", 32'({busy, step_oh}), 32'(0));

        // Reset in EXEC step 2, then a clean restart.
        set_in(1, 0, 0, 0, 0, 3'd0, 0); tick();
        set_in(0, 1, 1, 0, 0, 3'd1, 0); tick();
        start = 0;
        repeat (12) tick();
        check("exec_step2", 32'({exec_act, step_oh}), 32'({1'b1, 5'b00100}));
        reset = 1; tick(); reset = 0;
        check("reset_mid_exec", 32'(dut_vec()), 32'(0));
        start = 1; tick(); start = 0;
        check("restart", 32'({fetch_act, step_oh, instr_cnt}), 32'({1'b1, 5'b00001, 4'd0}));

        // Counter wrap over 16 skipped instructions.
        set_in(1, 0, 0, 0, 0, 3'd0, 0); tick();
        set_in(0, 1, 1, 0, 0, 3'd6, 0); tick();
        start = 0;
        repeat (150) tick();
        check("cnt_15", 32'(instr_cnt), 32'd15);
        repeat (10) tick();
        check("cnt_wrap", 32'({done, skipped, instr_cnt}), 32'({1'b1, 1'b1, 4'd0}));

        // Start ignored while busy; run dropped during EXEC finishes the instruction.
        set_in(1, 0, 0, 0, 0, 3'd0, 0); tick();
        set_in(0, 1, 1, 0, 0, 3'd2, 1); tick();
        tick();
        tick();
        start = 0;
        check("start_ignored", 32'({fetch_act, step_oh}), 32'({1'b1, 5'b00100}));
        repeat (8) tick();
        run = 0;
        repeat (5) tick();
        check("run_drop_done", 32'({busy, done, fetch_act, instr_cnt}),
              32'({1'b0, 1'b1, 1'b0, 4'd1}));
        tick();
        check("run_drop_idle", 32'({busy, done}), 32'(0));

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            set_in($urandom_range(199) == 0, $urandom_range(7) == 0, $urandom_range(9) != 0,
                   $urandom_range(3) == 0, $urandom_range(2) == 0, 3'($urandom),
                   1'($urandom));
            tick();
        end
        check("final_cycle", 32'(dut_vec()), 32'(model_vec()));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
